// File: rtl/erx_idelay_cal.sv
`default_nettype none
// ============================================================================
// Module      : erx_idelay_cal
// Description : Tap sequencer for the nine receive-path IDELAYE2 elements of
//               the elink receiver (data lanes 7:0, frame on lane 8). Taps are
//               either written directly or found by a calibration sweep that
//               loads taps 0..31 on all lanes, scores a per-lane pattern-match
//               stream and applies the centre of each lane's passing window.
//               Runs entirely in the slow (div4) clock domain.
// Ports       :
//   clk          slow clock, also the IDELAY C clock
//   nreset       asynchronous active-low reset
//   cfg_write    one-cycle strobe: load cfg_taps directly (IDLE only)
//   cfg_taps     manual taps, lane j at bits [5j+4:5j]
//   cal_start    one-cycle strobe: start a calibration sweep (IDLE only)
//   match_valid  a pattern-checker beat is present this cycle
//   match_ok     per-lane pass for the current beat
//   idelay_value tap bus to the IDELAYs, same packing as cfg_taps
//   load_taps    one-cycle tap-load strobe
//   cal_busy     calibration in progress
//   cal_done     one-cycle pulse after the final taps were applied
//   cal_fail     lanes with no passing tap in the last sweep
// Revision    : 1.0  initial release
// ============================================================================
module erx_idelay_cal #(
    parameter int SETTLE  = 8,
    parameter int SAMPLES = 64,
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        cfg_write,
    input  logic [44:0] cfg_taps,
    input  logic        cal_start,
    input  logic        match_valid,
    input  logic [8:0]  match_ok,
    output logic [44:0] idelay_value,
    output logic        load_taps,
    output logic        cal_busy,
    output logic        cal_done,
    output logic [8:0]  cal_fail
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_MEASURE = 3'd3;
    localparam logic [2:0] ST_NEXT    = 3'd4;
    localparam logic [2:0] ST_APPLY   = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    localparam int SAMPLE_W  = $clog2(SAMPLES + 1);
    localparam int TIMEOUT_W = $clog2(TIMEOUT + 1);

    localparam logic [7:0]           SETTLE_INIT  = 8'(SETTLE);
    localparam logic [SAMPLE_W-1:0]  SAMPLE_LAST  = SAMPLE_W'(SAMPLES);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT);

    logic [2:0]           state;
    logic [2:0]           next_state;
    logic [4:0]           tap;
    logic [7:0]           settle_cnt;
    logic [SAMPLE_W-1:0]  sample_cnt;
    logic [TIMEOUT_W-1:0] timeout_cnt;
    logic [8:0]           err;
    logic [8:0]           found;
    logic [44:0]          first_tap;
    logic [44:0]          last_tap;
    logic [44:0]          final_taps;

    logic [44:0]          idelay_d;
    logic                 load_d;
    logic                 busy_d;
    logic                 done_d;

    logic settle_end;
    logic sample_end;
    logic timeout_end;

    // The settle counter is loaded with SETTLE and the decrement that takes it
    // to zero is the last SETTLE cycle, giving exactly SETTLE idle cycles.
    assign settle_end  = (settle_cnt == 8'd1);
    assign sample_end  = match_valid && ((sample_cnt + SAMPLE_W'(1)) == SAMPLE_LAST);
    assign timeout_end = ((timeout_cnt + TIMEOUT_W'(1)) == TIMEOUT_LAST);

    // Window centre per lane: (first + last) >> 1 with a 6-bit sum so 31+31
    // does not wrap. Lanes that never passed park at tap 0.
    generate
        for (genvar g = 0; g < 9; g++) begin : g_lane
            logic [5:0] lane_sum;
            assign lane_sum = {1'b0, first_tap[5*g +: 5]} + {1'b0, last_tap[5*g +: 5]};
            assign final_taps[5*g +: 5] = found[g] ? 5'(lane_sum >> 1) : 5'd0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (cal_start) next_state = ST_LOAD;
            ST_LOAD:    next_state = ST_SETTLE;
            ST_SETTLE:  if (settle_end) next_state = ST_MEASURE;
            ST_MEASURE: if (sample_end || timeout_end) next_state = ST_NEXT;
            ST_NEXT:    next_state = (tap == 5'd31) ? ST_APPLY : ST_LOAD;
            ST_APPLY:   next_state = ST_DONE;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        idelay_d = idelay_value;
        load_d   = 1'b0;
        busy_d   = (next_state != ST_IDLE);
        done_d   = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                // cal_start has priority; a simultaneous cfg_write is dropped.
                if (cfg_write && !cal_start) begin
                    idelay_d = cfg_taps;
                    load_d   = 1'b1;
                end
            end
            ST_LOAD: begin
                idelay_d = {9{tap}};
                load_d   = 1'b1;
            end
            ST_APPLY: begin
                idelay_d = final_taps;
                load_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            idelay_value <= 45'd0;
            load_taps    <= 1'b0;
            cal_busy     <= 1'b0;
            cal_done     <= 1'b0;
        end else begin
            idelay_value <= idelay_d;
            load_taps    <= load_d;
            cal_busy     <= busy_d;
            cal_done     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Sweep datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tap         <= 5'd0;
            settle_cnt  <= 8'd0;
            sample_cnt  <= '0;
            timeout_cnt <= '0;
            err         <= 9'd0;
            found       <= 9'd0;
            first_tap   <= 45'd0;
            last_tap    <= 45'd0;
            cal_fail    <= 9'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cal_start) begin
                        tap       <= 5'd0;
                        found     <= 9'd0;
                        first_tap <= 45'd0;
                        last_tap  <= 45'd0;
                        cal_fail  <= 9'd0;
                    end
                end
                ST_LOAD: begin
                    settle_cnt <= SETTLE_INIT;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 8'd1;
                    if (settle_end) begin
                        err         <= 9'd0;
                        sample_cnt  <= '0;
                        timeout_cnt <= '0;
                    end
                end
                ST_MEASURE: begin
                    timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
                    if (match_valid) begin
                        sample_cnt <= sample_cnt + SAMPLE_W'(1);
                        err        <= err | ~match_ok;
                    end
                    // A starved checker marks the tap bad on every lane; a
                    // beat completing the sample set in the same cycle wins.
                    if (timeout_end && !sample_end) begin
                        err <= 9'h1FF;
                    end
                end
                ST_NEXT: begin
                    for (int l = 0; l < 9; l++) begin
                        if (!err[l]) begin
                            if (!found[l]) begin
                                first_tap[5*l +: 5] <= tap;
                            end
                            found[l]           <= 1'b1;
                            last_tap[5*l +: 5] <= tap;
                        end
                    end
                    if (tap != 5'd31) begin
                        tap <= tap + 5'd1;
                    end
                end
                ST_APPLY: begin
                    cal_fail <= ~found;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_erx_idelay_cal.sv
`default_nettype none
// ============================================================================
// Module      : tb_erx_idelay_cal
// Description : Self-checking bench for erx_idelay_cal. A small channel model
//               turns the applied tap of each lane into match_ok using a
//               per-lane passing window; expected results are hand-computed.
// Revision    : 1.0  initial release
// ============================================================================
module tb_erx_idelay_cal;

    localparam logic [44:0] PATTERN = 45'h0123_4567_89AB;

    logic        clk = 1'b0;
    logic        nreset;
    logic        cfg_write;
    logic [44:0] cfg_taps;
    logic        cal_start;
    logic        match_valid;
    logic [8:0]  match_ok;
    logic [44:0] idelay_value;
    logic        load_taps;
    logic        cal_busy;
    logic        cal_done;
    logic [8:0]  cal_fail;

    int checks = 0;
    int errors = 0;

    int  lo [9];
    int  hi [9];
    logic stall5;

    always #5 clk = ~clk;

    erx_idelay_cal dut (
        .clk          (clk),
        .nreset       (nreset),
        .cfg_write    (cfg_write),
        .cfg_taps     (cfg_taps),
        .cal_start    (cal_start),
        .match_valid  (match_valid),
        .match_ok     (match_ok),
        .idelay_value (idelay_value),
        .load_taps    (load_taps),
        .cal_busy     (cal_busy),
        .cal_done     (cal_done),
        .cal_fail     (cal_fail)
    );

    // Channel model: lane passes when its applied tap lies inside [lo, hi].
    always_comb begin
        for (int l = 0; l < 9; l++) begin
            match_ok[l] = (int'(idelay_value[5*l +: 5]) >= lo[l]) &&
                          (int'(idelay_value[5*l +: 5]) <= hi[l]);
        end
        match_valid = !(stall5 && (idelay_value == {9{5'd5}}));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_windows(input int l0, input int h0, input int lr, input int hr);
        lo[0] = l0;
        hi[0] = h0;
        for (int l = 1; l < 9; l++) begin
            lo[l] = lr;
            hi[l] = hr;
        end
    endtask

    function automatic logic [44:0] pack(input int t [9]);
        logic [44:0] v;
        v = '0;
        for (int l = 0; l < 9; l++) v[5*l +: 5] = 5'(t[l]);
        return v;
    endfunction

    // Called at a negedge. Optionally disturbs the sweep with ignored strobes
    // (including one in the DONE cycle) and starts with both strobes at once.
    task automatic run_sweep(input bit dirty, input bit both,
                             output int cyc, output int loads, output bit saw_pattern);
        cal_start = 1'b1;
        cfg_write = both;
        cfg_taps  = PATTERN;
        @(negedge clk);
        cal_start = 1'b0;
        cfg_write = 1'b0;
        check("busy_rise", cal_busy, 1);
        check("fail_cleared", cal_fail, 0);
        cyc = 0;
        loads = 0;
        saw_pattern = 1'b0;
        while (!cal_done && cyc < 6000) begin
            if (load_taps) loads++;
            if (idelay_value == PATTERN) saw_pattern = 1'b1;
            cal_start = dirty && (cyc == 100 || cyc == 1000 || (load_taps && loads == 33));
            cfg_write = dirty && (cyc == 100 || cyc == 1500 || (load_taps && loads == 33));
            cfg_taps  = PATTERN;
            @(negedge clk);
            cyc++;
        end
        cal_start = 1'b0;
        cfg_write = 1'b0;
        check("busy_low_at_done", cal_busy, 0);
    endtask

    typedef struct packed {
        logic        wr;
        logic [44:0] taps;
        logic [44:0] exp_val;
        logic        exp_load;
    } vec_t;

    vec_t vecs [5];

    int   cyc;
    int   loads;
    bit   saw;
    int   guard;
    int   tap_b [9];
    int   tap_t [9];
    logic [44:0] exp_a;

    initial begin
        vecs[0] = '{1'b1, 45'h1F_0842_1084,  45'h1F_0842_1084,  1'b1};
        vecs[1] = '{1'b0, 45'h0000_0000_0000, 45'h1F_0842_1084, 1'b0};
        vecs[2] = '{1'b1, 45'h1FFF_FFFF_FFFF, 45'h1FFF_FFFF_FFFF, 1'b1};
        vecs[3] = '{1'b1, 45'h0012_3456_789A, 45'h0012_3456_789A, 1'b1};
        vecs[4] = '{1'b0, 45'h1555_5555_5555, 45'h0012_3456_789A, 1'b0};
        exp_a = {9{5'd15}};
        tap_b = '{31, 15, 15, 0, 15, 15, 15, 15, 30};
        tap_t = '{7, 7, 7, 7, 7, 7, 7, 7, 7};

        nreset    = 1'b0;
        cfg_write = 1'b0;
        cfg_taps  = '0;
        cal_start = 1'b0;
        stall5    = 1'b0;
        set_windows(10, 20, 3, 28);

        repeat (2) @(negedge clk);
        check("rst_value", idelay_value, 0);
        check("rst_load", load_taps, 0);
        check("rst_busy", cal_busy, 0);
        check("rst_done", cal_done, 0);
        check("rst_fail", cal_fail, 0);
        nreset = 1'b1;
        @(negedge clk);

        // Manual writes
        for (int i = 0; i < 5; i++) begin
            cfg_write = vecs[i].wr;
            cfg_taps  = vecs[i].taps;
            @(negedge clk);
            cfg_write = 1'b0;
            check($sformatf("man_value[%0d]", i), idelay_value, vecs[i].exp_val);
            check($sformatf("man_load[%0d]", i), load_taps, vecs[i].exp_load);
            check($sformatf("man_busy[%0d]", i), cal_busy, 0);
        end

        // Undisturbed sweep: lane 0 eye 10..20, others 3..28
        run_sweep(1'b0, 1'b0, cyc, loads, saw);
        check("A_cycles", cyc, 2370);
        check("A_loads", loads, 33);
        check("A_value", idelay_value, exp_a);
        check("A_fail", cal_fail, 0);

        // Chained start in the cal_done cycle (first IDLE) with a simultaneous
        // cfg_write, plus ignored strobes mid-sweep and in DONE.
        run_sweep(1'b1, 1'b1, cyc, loads, saw);
        check("D_cycles", cyc, 2370);
        check("D_loads", loads, 33);
        check("D_value", idelay_value, exp_a);
        check("D_fail", cal_fail, 0);
        check("D_pattern_never_loaded", saw, 0);
        @(negedge clk);
        check("D_done_pulse_end", cal_done, 0);
        check("D_done_start_ignored", cal_busy, 0);
        check("D_no_extra_load", load_taps, 0);

        // Edge eye on lane 8, dead lane 3, 31..31 on lane 0
        set_windows(31, 31, 3, 28);
        lo[3] = 31; hi[3] = 0;
        lo[8] = 30; hi[8] = 31;
        run_sweep(1'b0, 1'b0, cyc, loads, saw);
        check("B_cycles", cyc, 2370);
        check("B_value", idelay_value, pack(tap_b));
        check("B_fail", cal_fail, 9'h008);
        @(negedge clk);
        check("B_fail_hold", cal_fail, 9'h008);

        // Checker starved during tap 5: tap 5 fails, window 6..8 -> 7
        set_windows(5, 8, 5, 8);
        stall5 = 1'b1;
        run_sweep(1'b0, 1'b0, cyc, loads, saw);
        stall5 = 1'b0;
        check("T_cycles", cyc, 2562);
        check("T_loads", loads, 33);
        check("T_value", idelay_value, pack(tap_t));
        check("T_fail", cal_fail, 0);
        @(negedge clk);

        // Reset during SETTLE of tap 12
        set_windows(10, 20, 3, 28);
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        guard = 0;
        while (!(load_taps && idelay_value == {9{5'd12}}) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("R_reach_tap12", guard < 2000, 1);
        @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        check("R_value", idelay_value, 0);
        check("R_load", load_taps, 0);
        check("R_busy", cal_busy, 0);
        check("R_done", cal_done, 0);
        check("R_fail", cal_fail, 0);
        loads = 0;
        repeat (4) begin
            @(negedge clk);
            if (load_taps) loads++;
        end
        check("R_no_load", loads, 0);
        nreset = 1'b1;
        @(negedge clk);
        check("R_idle_after", cal_busy, 0);
        run_sweep(1'b0, 1'b0, cyc, loads, saw);
        check("R2_cycles", cyc, 2370);
        check("R2_loads", loads, 33);
        check("R2_value", idelay_value, exp_a);
        check("R2_fail", cal_fail, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
